reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Shares the internal register bus (address/bytecount/data/read/write/addrvalid, as consumed by reg_chipwhisperer, reg_clockglitch and reg_reconfig) between two masters. M0 is the USB host path; M1 is an on-chip configuration sequencer. The arbiter is fixed-priority with an anti-starvation counter and a burst lock. It serialises each access into a three-phase bus cycle and returns read data with a one-cycle ack. It sits between the host interface and the register slaves, and replaces direct drive of the bus by the host interface.

## Interface
Parameters:
- ADDR_W, 6, register address width
- DATA_W, 8, data width
- BCNT_W, 16, byte-count width
- MAX_WAIT, 4, consecutive M0 grants while M1 waits before M1 is forced to win (1..15)

Ports:
- clk  in  1  single clock domain; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mN_req  in  1  (N=0,1) transaction request; hold with fields stable until mN_ack
- mN_lock  in  1  keep grant for next transaction; sampled in the ack cycle
- mN_write  in  1  1=write, 0=read
- mN_addr  in  ADDR_W  register address
- mN_bcnt  in  BCNT_W  byte index within the register
- mN_wdata  in  DATA_W  write data
- mN_ack  out  1  one-cycle completion pulse
- mN_rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack
- reg_address  out  ADDR_W  bus address
- reg_bytecnt  out  BCNT_W  bus byte count
- reg_datao  out  DATA_W  bus write data (to slaves' reg_datai)
- reg_datai  in  DATA_W  OR-combined slave read data
- reg_read  out  1  read strobe
- reg_write  out  1  write strobe
- reg_addrvalid  out  1  address phase valid
- grant  out  1  current/last owner (0=M0, 1=M1)
- busy  out  1  transaction in progress

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: arbitrate among asserted requests.
  - M0 wins, unless M1 req=1 and wait_cnt==MAX_WAIT; then M1 wins.
  - Winner registered into grant; latch its addr/bcnt/write/wdata; go to SETUP.
  - No request: stay in IDLE.
- SETUP: reg_addrvalid=1; reg_address, reg_bytecnt and reg_datao driven from the latch → ACCESS.
- ACCESS: reg_addrvalid=1; exactly one of reg_read or reg_write =1 → DONE.
- DONE: reg_addrvalid=1.
  - For a read, sample reg_datai into mN_rdata of the owner.
  - Pulse mN_ack of the owner.
  - If owner lock=1 and owner req=1, re-latch the owner's fields → SETUP, skipping arbitration.
  - Exception: if the other master has saturated wait_cnt, go to IDLE.
  - Otherwise → IDLE.
- wait_cnt (4 bit):
  - Increments, saturating at MAX_WAIT, each time M0 is granted while M1 req=1.
  - Clears when M1 is granted.
  - Also clears when M1 req=0 in IDLE.
  - Saturated wait_cnt also breaks an M0 lock.
  - M1 lock is never broken, because M0 has priority anyway.
- A request dropped mid-transaction is not aborted: the bus cycle completes and ack still pulses.
- reg_datao is driven for reads too (latched wdata); slaves ignore it.

## Timing
- Request sampled in IDLE at cycle N:
  - SETUP at N+1
  - ACCESS (strobe) at N+2
  - DONE/ack at N+3
  - Latency is 3 cycles.
- Locked back-to-back transfers: one access every 3 cycles (DONE→SETUP).
- Unlocked back-to-back: 4 cycles (DONE→IDLE→SETUP).
- Requests that arrive simultaneously in IDLE resolve the same cycle by the rule above.
- reset_n low at any time forces, asynchronously:
  - state=IDLE
  - all strobes, reg_addrvalid, acks and busy =0
  - reg_address, reg_bytecnt, reg_datao, mN_rdata =0
  - grant=0, wait_cnt=0
- A transaction interrupted by reset is lost; no ack is produced.
- busy=1 in SETUP/ACCESS/DONE, and 0 in IDLE.

## Structure
- Shared package reg_bus_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/DONE)
  - default widths ADDR_W/DATA_W/BCNT_W
  - master-index constants M0=0, M1=1
- One sub-module: reg_bus_prio, a combinational winner select plus the registered wait_cnt with saturation.
- The FSM, latches and the bus drive live in the top.

## Test plan
- Single M0 read: addr=0x1A, bcnt=2, slave returns 0x5C → reg_read high only at N+2; m0_ack at N+3 with m0_rdata=0x5C; m1_ack stays 0.
- Simultaneous M0 write 0xA5@0x03 and M1 write 0x3C@0x07 → M0 goes first (strobe N+2); M1 strobe at N+6; grant 0 then 1.
- Starvation: M0 requests continuously unlocked, M1 requests continuously, MAX_WAIT=4 → after 4 M0 grants, the 5th grant goes to M1 and wait_cnt returns to 0.
- Lock burst: M1 lock=1 with 4 reads at bcnt 0..3 → acks every 3 cycles with no IDLE between; M0 request in the meantime waits until lock drops.
- M0 lock held continuously with M1 waiting → the lock is broken after MAX_WAIT M0 transfers and M1 is served next.
- reset_n pulled low during ACCESS → all outputs 0 immediately, no ack; after release, a new M1 request completes normally in 3 cycles.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the two-master register bus arbiter.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_t;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_BCNT_W = 16;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/reg_bus_arbiter_prio.sv
// Fixed-priority winner select (M0 first) with a saturating M1 wait counter.
module reg_bus_prio
    import reg_bus_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic m0_req,
    input  logic m1_req,
    input  logic arb_en,
    input  logic relock_en,
    input  logic relock_owner,
    output logic win,
    output logic wait_sat
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       grant_evt;
    logic       grant_owner;

    assign wait_sat    = (wait_cnt == WAIT_MAX);
    assign win         = (m1_req && (!m0_req || wait_sat)) ? M1 : M0;
    assign grant_evt   = (arb_en && (m0_req || m1_req)) || relock_en;
    assign grant_owner = arb_en ? win : relock_owner;

    // Locked re-grants count as grants, so a long M0 burst still ages M1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 4'd0;
        end else if (grant_evt && (grant_owner == M1)) begin
            wait_cnt <= 4'd0;
        end else if (grant_evt && m1_req) begin
            if (!wait_sat) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else if (arb_en && !m1_req) begin
            wait_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master register bus arbiter: serialises each access into SETUP/ACCESS/DONE.
// state     | meaning
// ST_IDLE   | arbitrate, latch winner's fields
// ST_SETUP  | address phase, bus fields valid
// ST_ACCESS | read or write strobe
// ST_DONE   | owner ack, read data captured; relock or return to idle
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BCNT_W   = DEF_BCNT_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [BCNT_W-1:0] m0_bcnt,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [BCNT_W-1:0] m1_bcnt,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] reg_address,
    output logic [BCNT_W-1:0] reg_bytecnt,
    output logic [DATA_W-1:0] reg_datao,
    input  logic [DATA_W-1:0] reg_datai,
    output logic              reg_read,
    output logic              reg_write,
    output logic              reg_addrvalid,
    output logic              grant,
    output logic              busy
);

    bus_state_t        state, state_nxt;
    logic              win, wait_sat;
    logic              arb_en, relock_en;
    logic              own_req, own_lock;
    logic              load, sel;
    logic              ack, rd_done;
    logic [ADDR_W-1:0] lat_addr;
    logic [BCNT_W-1:0] lat_bcnt;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_write;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    reg_bus_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_req       (m0_req),
        .m1_req       (m1_req),
        .arb_en       (arb_en),
        .relock_en    (relock_en),
        .relock_owner (grant),
        .win          (win),
        .wait_sat     (wait_sat)
    );

    assign own_req  = (grant == M1) ? m1_req  : m0_req;
    assign own_lock = (grant == M1) ? m1_lock : m0_lock;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        relock_en = 1'b0;
        case (state)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (m0_req || m1_req) state_nxt = ST_SETUP;
            end
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE: begin
                // A saturated wait counter only ever breaks an M0 lock.
                if (own_lock && own_req && !((grant == M0) && wait_sat)) begin
                    relock_en = 1'b1;
                    state_nxt = ST_SETUP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load = (arb_en && (m0_req || m1_req)) || relock_en;
    assign sel  = arb_en ? win : grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant     <= M0;
            lat_addr  <= '0;
            lat_bcnt  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else if (load) begin
            grant     <= sel;
            lat_addr  <= (sel == M1) ? m1_addr  : m0_addr;
            lat_bcnt  <= (sel == M1) ? m1_bcnt  : m0_bcnt;
            lat_wdata <= (sel == M1) ? m1_wdata : m0_wdata;
            lat_write <= (sel == M1) ? m1_write : m0_write;
        end
    end

    assign ack     = (state == ST_DONE);
    assign rd_done = ack && !lat_write;
    assign m0_ack  = ack && (grant == M0);
    assign m1_ack  = ack && (grant == M1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else if (rd_done) begin
            if (grant == M1) m1_rdata_q <= reg_datai;
            else             m0_rdata_q <= reg_datai;
        end
    end

    // Bypass so read data is already valid in the ack cycle.
    assign m0_rdata = (m0_ack && rd_done) ? reg_datai : m0_rdata_q;
    assign m1_rdata = (m1_ack && rd_done) ? reg_datai : m1_rdata_q;

    assign reg_address   = lat_addr;
    assign reg_bytecnt   = lat_bcnt;
    assign reg_datao     = lat_wdata;
    assign reg_addrvalid = (state != ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign reg_read      = (state == ST_ACCESS) && !lat_write;
    assign reg_write     = (state == ST_ACCESS) && lat_write;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: arbitration order, timing, locks, starvation and reset.
module tb_reg_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 0, m0_lock = 0, m0_write = 0;
    logic [5:0]  m0_addr = '0;
    logic [15:0] m0_bcnt = '0;
    logic [7:0]  m0_wdata = '0;
    logic        m0_ack;
    logic [7:0]  m0_rdata;
    logic        m1_req = 0, m1_lock = 0, m1_write = 0;
    logic [5:0]  m1_addr = '0;
    logic [15:0] m1_bcnt = '0;
    logic [7:0]  m1_wdata = '0;
    logic        m1_ack;
    logic [7:0]  m1_rdata;
    logic [5:0]  reg_address;
    logic [15:0] reg_bytecnt;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai;
    logic        reg_read, reg_write, reg_addrvalid, grant, busy;

    int checks = 0;
    int errors = 0;

    reg_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_bcnt(m0_bcnt), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_bcnt(m1_bcnt), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
        .reg_datai(reg_datai), .reg_read(reg_read), .reg_write(reg_write),
        .reg_addrvalid(reg_addrvalid), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave: 0x1A byte 2 reads 0x5C, anything else reads 0xB0 + byte index.
    always_comb begin
        reg_datai = 8'h00;
        if (reg_addrvalid) begin
            if (reg_address == 6'h1A && reg_bytecnt == 16'd2) reg_datai = 8'h5C;
            else reg_datai = 8'hB0 + reg_bytecnt[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        m0_req = 0; m0_lock = 0; m1_req = 0; m1_lock = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, n0, n1, nack, nw, gaps, m0c, m1c;
        int w_cyc[4];
        logic [7:0] w_addr[4], w_data[4];
        logic w_grant[4];
        int ack_cyc[8];
        logic own[8];
        int m0cs[8];
        logic [7:0] burst_rd[4];
        logic [7:0] m0_rd, m1_rd;
        logic done;

        // ---------------- reset state
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_addrvalid", 32'(reg_addrvalid), 0);
        do_reset();

        // ---------------- single M0 read 0x1A byte 2
        @(posedge clk);
        #1 m0_addr = 6'h1A; m0_bcnt = 16'd2; m0_write = 0; m0_req = 1;
        @(negedge clk);
        check("t1_n_busy", 32'(busy), 0);
        @(negedge clk);
        check("t1_n1_addrvalid", 32'(reg_addrvalid), 1);
        check("t1_n1_read", 32'(reg_read), 0);
        check("t1_n1_addr", 32'(reg_address), 32'h1A);
        @(negedge clk);
        check("t1_n2_read", 32'(reg_read), 1);
        check("t1_n2_write", 32'(reg_write), 0);
        check("t1_n2_ack", 32'(m0_ack), 0);
        @(negedge clk);
        check("t1_n3_ack", 32'(m0_ack), 1);
        check("t1_n3_rdata", 32'(m0_rdata), 32'h5C);
        check("t1_n3_m1ack", 32'(m1_ack), 0);
        check("t1_n3_read", 32'(reg_read), 0);
        m0_req = 0;
        @(negedge clk);
        check("t1_n4_ack", 32'(m0_ack), 0);
        check("t1_n4_busy", 32'(busy), 0);
        check("t1_n4_rdata_hold", 32'(m0_rdata), 32'h5C);

        // ---------------- simultaneous writes
        do_reset();
        @(posedge clk);
        #1;
        m0_write = 1; m0_addr = 6'h03; m0_wdata = 8'hA5; m0_bcnt = 0; m0_req = 1;
        m1_write = 1; m1_addr = 6'h07; m1_wdata = 8'h3C; m1_bcnt = 0; m1_req = 1;
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (reg_write && nw < 4) begin
                w_cyc[nw] = c; w_addr[nw] = {2'b00, reg_address}; w_data[nw] = reg_datao;
                w_grant[nw] = grant; nw++;
            end
            if (m0_ack) m0_req = 0;
            if (m1_ack) m1_req = 0;
        end
        check("t2_nwrites", nw, 2);
        if (nw == 2) begin
            check("t2_w0_cyc", w_cyc[0], 2);
            check("t2_w0_addr", 32'(w_addr[0]), 32'h03);
            check("t2_w0_data", 32'(w_data[0]), 32'hA5);
            check("t2_w0_grant", 32'(w_grant[0]), 0);
            check("t2_w1_cyc", w_cyc[1], 6);
            check("t2_w1_addr", 32'(w_addr[1]), 32'h07);
            check("t2_w1_data", 32'(w_data[1]), 32'h3C);
            check("t2_w1_grant", 32'(w_grant[1]), 1);
        end

        // ---------------- starvation, unlocked M0 continuously requesting
        do_reset();
        @(posedge clk);
        #1;
        m0_write = 0; m0_addr = 6'h1A; m0_bcnt = 2; m0_req = 1;
        m1_write = 0; m1_addr = 6'h10; m1_bcnt = 1; m1_req = 1;
        nack = 0; k = 0;
        while (nack < 5 && k < 40) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                own[nack] = m1_ack; ack_cyc[nack] = k;
                if (nack == 3) check("t3_wait_sat", 32'(u_wait()), 4);
                if (m1_ack) begin
                    check("t3_wait_clr", 32'(u_wait()), 0);
                    m1_req = 0;
                end
                nack++;
            end
            k++;
        end
        m0_req = 0;
        check("t3_nack", nack, 5);
        if (nack == 5) begin
            for (int i = 0; i < 4; i++) check("t3_owner_m0", 32'(own[i]), 0);
            check("t3_owner_m1", 32'(own[4]), 1);
            check("t3_unlocked_gap", ack_cyc[1] - ack_cyc[0], 4);
            check("t3_m1_cyc", ack_cyc[4], 19);
        end

        // ---------------- M1 locked burst of 4 reads, M0 waiting
        do_reset();
        @(posedge clk);
        #1;
        m1_write = 0; m1_addr = 6'h10; m1_bcnt = 0; m1_lock = 1; m1_req = 1;
        n1 = 0; gaps = 0; m0c = -1; done = 0; k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            if (m1_ack && n1 < 4) begin
                ack_cyc[n1] = k; burst_rd[n1] = m1_rdata; n1++;
                m1_bcnt = 16'(n1);
                if (n1 == 4) begin m1_req = 0; m1_lock = 0; end
            end
            if (m0_ack) begin m0c = k; m0_rd = m0_rdata; m0_req = 0; done = 1; end
            if (n1 >= 1 && n1 < 4 && !busy) gaps++;
            if (k == 1) begin
                m0_write = 0; m0_addr = 6'h1A; m0_bcnt = 2; m0_req = 1;
            end
            k++;
        end
        check("t4_n1", n1, 4);
        if (n1 == 4) begin
            check("t4_ack0", ack_cyc[0], 3);
            check("t4_ack1", ack_cyc[1], 6);
            check("t4_ack2", ack_cyc[2], 9);
            check("t4_ack3", ack_cyc[3], 12);
            check("t4_rd0", 32'(burst_rd[0]), 32'hB0);
            check("t4_rd1", 32'(burst_rd[1]), 32'hB1);
            check("t4_rd2", 32'(burst_rd[2]), 32'hB2);
            check("t4_rd3", 32'(burst_rd[3]), 32'hB3);
        end
        check("t4_no_idle", gaps, 0);
        check("t4_m0_cyc", m0c, 16);
        check("t4_m0_rdata", 32'(m0_rd), 32'h5C);

        // ---------------- M0 lock broken by saturated wait counter
        do_reset();
        @(posedge clk);
        #1;
        m0_write = 1; m0_addr = 6'h05; m0_wdata = 8'h11; m0_bcnt = 0; m0_lock = 1; m0_req = 1;
        m1_write = 0; m1_addr = 6'h1A; m1_bcnt = 2; m1_req = 1;
        n0 = 0; m1c = -1; done = 0; k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            if (m0_ack && n0 < 8) begin m0cs[n0] = k; n0++; end
            if (m1_ack) begin
                m1c = k; m1_rd = m1_rdata; done = 1;
                m1_req = 0; m0_req = 0; m0_lock = 0;
            end
            k++;
        end
        check("t5_n0", n0, 4);
        if (n0 == 4) begin
            check("t5_m0_ack0", m0cs[0], 3);
            check("t5_m0_ack3", m0cs[3], 12);
        end
        check("t5_m1_cyc", m1c, 16);
        check("t5_m1_rdata", 32'(m1_rd), 32'h5C);

        // ---------------- reset during ACCESS, then fresh M1 read
        @(negedge clk);
        @(posedge clk);
        #1;
        m1_write = 1; m1_addr = 6'h2A; m1_bcnt = 5; m1_wdata = 8'h77; m1_req = 1;
        repeat (3) @(negedge clk);
        check("t6_access_write", 32'(reg_write), 1);
        check("t6_access_grant", 32'(grant), 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_write", 32'(reg_write), 0);
        check("t6_rst_addrvalid", 32'(reg_addrvalid), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_addr", 32'(reg_address), 0);
        check("t6_rst_bcnt", 32'(reg_bytecnt), 0);
        check("t6_rst_datao", 32'(reg_datao), 0);
        check("t6_rst_grant", 32'(grant), 0);
        check("t6_rst_m0rdata", 32'(m0_rdata), 0);
        check("t6_rst_m1rdata", 32'(m1_rdata), 0);
        check("t6_rst_ack", 32'(m1_ack), 0);
        m1_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        nack = 0;
        repeat (3) begin
            @(negedge clk);
            if (m0_ack || m1_ack) nack++;
        end
        check("t6_no_ack", nack, 0);
        @(posedge clk);
        #1;
        m1_write = 0; m1_addr = 6'h1A; m1_bcnt = 2; m1_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("t6_n1_ack", 32'(m1_ack), 0);
        @(negedge clk);
        check("t6_n2_read", 32'(reg_read), 1);
        @(negedge clk);
        check("t6_n3_ack", 32'(m1_ack), 1);
        check("t6_n3_rdata", 32'(m1_rdata), 32'h5C);
        check("t6_n3_grant", 32'(grant), 1);
        m1_req = 0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [3:0] u_wait();
        return dut.u_prio.wait_cnt;
    endfunction

endmodule
